// File: rtl/tail_light_pkg.sv
// Shared types and lamp patterns for the tail-light sequencer.
// Hazard states exist only when TAIL_LIGHT_HAZARD_EN is defined.
package tail_light_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_L1,
        ST_L2,
        ST_L3,
        ST_R1,
        ST_R2,
        ST_R3
`ifdef TAIL_LIGHT_HAZARD_EN
        ,
        ST_HAZ_ON,
        ST_HAZ_OFF
`endif
    } state_t;

    localparam logic [2:0] PAT_OFF = 3'b000;
    localparam logic [2:0] PAT_1   = 3'b001;
    localparam logic [2:0] PAT_2   = 3'b011;
    localparam logic [2:0] PAT_3   = 3'b111;

    // Returns {lamp_r, lamp_l} for a given state.
    function automatic logic [5:0] lamps_for(input state_t s);
        logic [5:0] lamps;
        lamps = {PAT_OFF, PAT_OFF};
        case (s)
            ST_L1:      lamps = {PAT_OFF, PAT_1};
            ST_L2:      lamps = {PAT_OFF, PAT_2};
            ST_L3:      lamps = {PAT_OFF, PAT_3};
            ST_R1:      lamps = {PAT_1, PAT_OFF};
            ST_R2:      lamps = {PAT_2, PAT_OFF};
            ST_R3:      lamps = {PAT_3, PAT_OFF};
`ifdef TAIL_LIGHT_HAZARD_EN
            ST_HAZ_ON:  lamps = {PAT_3, PAT_3};
`endif
            default:    lamps = {PAT_OFF, PAT_OFF};
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/tail_light_sequencer_tick_gen.sv
// Free-running divider: tick is high for one clk_in cycle out of every TICK_DIV.
module tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk_in,
    input  logic reset,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/tail_light_sequencer.sv
// Tail-light controller: latches turn requests, arbitrates, steps lamp patterns per tick.
// Optional hazard flasher is built when TAIL_LIGHT_HAZARD_EN is defined.
module tail_light_sequencer
    import tail_light_pkg::*;
#(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       left_req,
    input  logic       right_req,
    input  logic       hazard_req,
    output logic [2:0] lamp_l,
    output logic [2:0] lamp_r,
    output logic       busy,
    output logic       done
);
    logic   tick;
    logic   left_prev, right_prev;
    logic   pend_l, pend_r;
    logic   last_r;
    logic   edge_l, edge_r;
    logic   start_l, start_r;
    state_t state_reg, state_next;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk_in (clk_in),
        .reset  (reset),
        .tick   (tick)
    );

    assign edge_l = left_req  & ~left_prev;
    assign edge_r = right_req & ~right_prev;

`ifndef TAIL_LIGHT_HAZARD_EN
    logic unused_hazard;
    assign unused_hazard = hazard_req;
`endif

    always_comb begin
        state_next = state_reg;
        start_l    = 1'b0;
        start_r    = 1'b0;
        if (tick) begin
            case (state_reg)
                ST_IDLE: begin
                    // On a tie, last_r picks the side not served last.
                    if (pend_l && (!pend_r || last_r)) begin
                        state_next = ST_L1;
                        start_l    = 1'b1;
                    end else if (pend_r) begin
                        state_next = ST_R1;
                        start_r    = 1'b1;
                    end
                end
                ST_L1:      state_next = ST_L2;
                ST_L2:      state_next = ST_L3;
                ST_L3:      state_next = ST_IDLE;
                ST_R1:      state_next = ST_R2;
                ST_R2:      state_next = ST_R3;
                ST_R3:      state_next = ST_IDLE;
`ifdef TAIL_LIGHT_HAZARD_EN
                ST_HAZ_ON:  state_next = ST_HAZ_OFF;
                ST_HAZ_OFF: state_next = hazard_req ? ST_HAZ_ON : ST_IDLE;
`endif
                default:    state_next = ST_IDLE;
            endcase
`ifdef TAIL_LIGHT_HAZARD_EN
            // Hazard overrides idle arbitration and pre-empts a running turn sequence;
            // suppressing the start keeps any pending bits for later.
            if (hazard_req && state_reg != ST_HAZ_ON && state_reg != ST_HAZ_OFF) begin
                state_next = ST_HAZ_ON;
                start_l    = 1'b0;
                start_r    = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            left_prev  <= 1'b0;
            right_prev <= 1'b0;
            pend_l     <= 1'b0;
            pend_r     <= 1'b0;
            last_r     <= 1'b1;
            lamp_l     <= PAT_OFF;
            lamp_r     <= PAT_OFF;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_reg  <= state_next;
            left_prev  <= left_req;
            right_prev <= right_req;
            // A new edge coinciding with the start re-queues the request.
            pend_l     <= edge_l | (pend_l & ~start_l);
            pend_r     <= edge_r | (pend_r & ~start_r);
            if (start_l) begin
                last_r <= 1'b0;
            end else if (start_r) begin
                last_r <= 1'b1;
            end
            {lamp_r, lamp_l} <= lamps_for(state_next);
            busy <= (state_next != ST_IDLE);
            done <= (state_reg != ST_IDLE) && (state_next == ST_IDLE);
        end
    end

endmodule
